// File: rtl/pwm_dac_pkg.sv
// Shared audio-DAC constants and sample type, imported by pwm_dac and by the waveform generators.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pwm_dac_pkg;

    // Native sample width of the audio path; the PWM period is 2**DAC_WIDTH cycles.
    localparam int DAC_WIDTH = 12;

    // Offset-binary zero level: a 50% duty cycle after the RC filter.
    localparam logic [DAC_WIDTH-1:0] DAC_MIDSCALE = 12'h800;

    typedef logic [DAC_WIDTH-1:0] dac_sample_t;

endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: free-running WIDTH-bit count while enabled, held at 0 while disabled.
// Latency: load_now is combinational from cnt/enable; cnt advances every enabled cycle.
// Backpressure: none; the counter never stalls.
//
// Ports:
//   clk       sole clock
//   rst       asynchronous active-low reset
//   enable    run control; low forces cnt to 0 and suppresses load_now
//   cnt       current position inside the PWM period
//   load_now  high in the last cycle of a period (cnt all ones) while enabled
module pwm_period_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] cnt,
    output logic             load_now
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}};

    // Natural wrap from all-ones to zero closes each period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign load_now = enable && (cnt == LAST);

endmodule

// File: rtl/pwm_dac.sv
// Sample-to-PWM converter: buffers one sample and applies it as duty at the next period boundary.
// Latency: 2 to 2**WIDTH+1 cycles from acceptance to first pwm_out cycle using the new duty.
// Backpressure: sample_ready low while a sample is pending, except in the boundary cycle.
//
// Ports:
//   clk           sole clock
//   rst           asynchronous active-low reset
//   enable        run control; low idles the PWM (output 0, no pulses), acceptance still works
//   sample        WIDTH-bit sample, offset binary (or two's complement when TWOS_COMP=1)
//   sample_valid  producer has a sample
//   sample_ready  block can take a sample this cycle (state only, no path from sample_valid)
//   pwm_out       registered PWM output
//   period_start  one-cycle pulse in the first cycle of each period (cnt == 0)
//   underflow     one-cycle pulse when a period starts with no pending sample
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int WIDTH     = DAC_WIDTH,
    parameter bit TWOS_COMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIDSCALE = MSB_MASK;

    logic [WIDTH-1:0] cnt;
    logic             load_now;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] pend;
    logic             pend_valid;
    logic [WIDTH-1:0] sample_conv;
    logic             accept;

    pwm_period_counter #(
        .WIDTH (WIDTH)
    ) u_period_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cnt      (cnt),
        .load_now (load_now)
    );

    // Two's complement to offset binary is a flip of the sign bit.
    assign sample_conv = TWOS_COMP ? (sample ^ MSB_MASK) : sample;

    // The boundary cycle frees the pending slot, so a new sample can enter
    // in the same cycle the old one moves into duty.
    assign sample_ready = !pend_valid || load_now;
    assign accept       = sample_valid && sample_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend       <= sample_conv;
            pend_valid <= 1'b1;
        end else if (load_now) begin
            pend_valid <= 1'b0;
        end
    end

    // Only a sample already pending at the boundary is applied; one arriving
    // in the boundary cycle waits a full period in pend.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty <= MIDSCALE;
        end else if (load_now && pend_valid) begin
            duty <= pend;
        end
    end

    // cnt never reaches duty when cnt is all ones, so the output is low in the
    // boundary-to-zero transition and a duty of D gives exactly D high cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            pwm_out      <= enable && (cnt < duty);
            period_start <= load_now;
            underflow    <= load_now && !pend_valid;
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
module tb_pwm_dac;
    import pwm_dac_pkg::*;

    localparam int P4  = 16;
    localparam int P12 = 1 << DAC_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // WIDTH=4 offset-binary instance
    logic       en4 = 1'b0, vld4 = 1'b0;
    logic [3:0] dat4 = '0;
    logic       rdy4, pwm4, ps4, uf4;

    // WIDTH=12 two's-complement instance
    logic        en12 = 1'b0, vld12 = 1'b0;
    dac_sample_t dat12 = '0;
    logic        rdy12, pwm12, ps12, uf12;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the WIDTH=4 instance: position in period, duty, pending queue
    int m_pos, m_duty;
    int m_pend[$];
    logic last_acc;

    // Observed high-cycle counts per completed period
    int win_q[$];
    int hc4, uf_cnt, ps_cnt;

    // WIDTH=12 bookkeeping
    int hc12, ps_bad, uf_bad, rdy_bad, off12, w12i;
    int w12[6];
    logic exp_ps12;
    dac_sample_t tc_in[3] = '{12'h000, 12'h7FF, 12'h800};
    int exp_w12[6];

    logic en_r;

    pwm_dac #(.WIDTH(4), .TWOS_COMP(1'b0)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .sample(dat4), .sample_valid(vld4),
        .sample_ready(rdy4), .pwm_out(pwm4), .period_start(ps4), .underflow(uf4)
    );

    pwm_dac #(.WIDTH(DAC_WIDTH), .TWOS_COMP(1'b1)) dut12 (
        .clk(clk), .rst(rst), .enable(en12), .sample(dat12), .sample_valid(vld12),
        .sample_ready(rdy12), .pwm_out(pwm12), .period_start(ps12), .underflow(uf12)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_wins(input string tag, input int n, input int e[5]);
        chk({tag, "_nwin"}, win_q.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_win%0d", tag, i), (i < win_q.size()) ? win_q[i] : -1, e[i]);
    endtask

    task automatic reset_model();
        m_pos  = 0;
        m_duty = 8;
        m_pend.delete();
        win_q.delete();
        hc4 = 0; uf_cnt = 0; ps_cnt = 0;
    endtask

    // One cycle of the WIDTH=4 instance, entered and left at a falling edge.
    task automatic cyc4(input logic en, input logic vld, input logic [3:0] dat);
        logic ld, exp_rdy, exp_pwm, exp_ps, exp_uf;
        en4 = en; vld4 = vld; dat4 = dat;
        #1;
        ld      = en && (m_pos == P4 - 1);
        exp_rdy = (m_pend.size() == 0) || ld;
        chk("rdy4", rdy4, exp_rdy);
        last_acc = vld && exp_rdy;
        exp_pwm  = en && (m_pos < m_duty);
        exp_ps   = ld;
        exp_uf   = ld && (m_pend.size() == 0);
        if (ld && m_pend.size() != 0) m_duty = m_pend.pop_front();
        if (last_acc) m_pend.push_back(int'(dat));
        m_pos = en ? (m_pos + 1) % P4 : 0;
        @(negedge clk);
        chk("pwm4", pwm4, exp_pwm);
        chk("ps4", ps4, exp_ps);
        chk("uf4", uf4, exp_uf);
        if (exp_ps) begin
            win_q.push_back(hc4);
            hc4 = 0;
        end
        hc4    += int'(pwm4);
        uf_cnt += int'(uf4);
        ps_cnt += int'(ps4);
    endtask

    initial begin
        exp_w12 = '{int'(DAC_MIDSCALE), int'(DAC_MIDSCALE), int'(DAC_MIDSCALE), 2048, 4095, 0};

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_pwm4", pwm4, 0);  chk("rst_ps4", ps4, 0);
        chk("rst_uf4", uf4, 0);    chk("rst_rdy4", rdy4, 1);
        chk("rst_pwm12", pwm12, 0); chk("rst_rdy12", rdy12, 1);

        // ---------------- 12-bit: idle periods, then two's-complement samples ----------------
        en12 = 1'b1;
        rst  = 1'b1;
        hc12 = 0; ps_bad = 0; uf_bad = 0; rdy_bad = 0;
        for (int n = 0; n < 6 * P12; n++) begin
            off12 = n % P12;
            w12i  = n / P12;
            if (n > 0 && off12 == 0) begin
                w12[w12i - 1] = hc12;
                hc12 = 0;
            end
            hc12 += int'(pwm12);
            exp_ps12 = (n > 0 && off12 == 0);
            if (ps12 !== exp_ps12) ps_bad++;
            if (uf12 !== (exp_ps12 && (w12i == 1 || w12i == 2))) uf_bad++;
            if (rdy12 !== !(w12i >= 2 && w12i <= 4 && off12 > 100 && off12 < P12 - 1)) rdy_bad++;
            vld12 = (w12i >= 2 && w12i <= 4 && off12 == 100);
            dat12 = (w12i >= 2 && w12i <= 4) ? tc_in[w12i - 2] : '0;
            @(negedge clk);
        end
        w12[5] = hc12;
        for (int i = 0; i < 6; i++) chk($sformatf("w12_high%0d", i), w12[i], exp_w12[i]);
        chk("w12_ps_pattern", ps_bad, 0);
        chk("w12_uf_pattern", uf_bad, 0);
        chk("w12_rdy_pattern", rdy_bad, 0);
        en12 = 1'b0;
        vld12 = 1'b0;

        // ---------------- 4-bit: steady stream 0,15,8,3 ----------------
        rst = 1'b0;
        #1;
        chk("rst2_rdy4", rdy4, 1);
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        begin
            int si;
            logic [3:0] stream [4];
            stream = '{4'd0, 4'd15, 4'd8, 4'd3};
            si = 0;
            for (int c = 0; c < 79; c++) begin
                if (si < 4) begin
                    cyc4(1'b1, 1'b1, stream[si]);
                    if (last_acc) si++;
                end else begin
                    cyc4(1'b1, 1'b0, 4'd0);
                end
            end
        end
        chk("stream_no_uf", uf_cnt, 0);
        cyc4(1'b1, 1'b0, 4'd0);
        chk_wins("stream", 5, '{8, 0, 15, 8, 3});

        // ---------------- boundary collision: 5 pending, 9 arrives at cnt=15 ----------------
        win_q.delete(); uf_cnt = 0;
        cyc4(1'b1, 1'b1, 4'd5);
        while (m_pos != P4 - 1) cyc4(1'b1, 1'b0, 4'd0);
        cyc4(1'b1, 1'b1, 4'd9);
        for (int c = 0; c < 31; c++) cyc4(1'b1, 1'b0, 4'd0);
        chk("collide_no_uf", uf_cnt, 0);
        cyc4(1'b1, 1'b0, 4'd0);
        chk_wins("collide", 3, '{3, 5, 9, 0, 0});

        // ---------------- underflow with same-cycle arrival ----------------
        win_q.delete(); uf_cnt = 0;
        while (m_pos != P4 - 1) cyc4(1'b1, 1'b0, 4'd0);
        cyc4(1'b1, 1'b1, 4'd2);
        chk("sc_uf_pulse", uf4, 1);
        chk("sc_ps_pulse", ps4, 1);
        for (int c = 0; c < 32; c++) cyc4(1'b1, 1'b0, 4'd0);
        chk_wins("samecyc", 3, '{9, 9, 2, 0, 0});
        chk("samecyc_uf_cnt", uf_cnt, 2);

        // ---------------- disable mid-period, accept while disabled, re-enable ----------------
        cyc4(1'b1, 1'b1, 4'd15);
        while (m_pos != P4 - 1) cyc4(1'b1, 1'b0, 4'd0);
        cyc4(1'b1, 1'b0, 4'd0);
        while (m_pos != 10) cyc4(1'b1, 1'b0, 4'd0);
        chk("pre_dis_pwm", pwm4, 1);
        uf_cnt = 0; ps_cnt = 0;
        cyc4(1'b0, 1'b1, 4'd6);
        chk("dis_pwm_low", pwm4, 0);
        for (int c = 0; c < 20; c++) cyc4(1'b0, 1'b0, 4'd0);
        chk("dis_no_ps", ps_cnt, 0);
        chk("dis_no_uf", uf_cnt, 0);
        win_q.delete(); hc4 = 0;
        for (int c = 0; c < 32; c++) cyc4(1'b1, 1'b0, 4'd0);
        chk_wins("reen", 2, '{15, 6, 0, 0, 0});

        // ---------------- reset mid-period with a sample pending ----------------
        cyc4(1'b1, 1'b1, 4'd1);
        cyc4(1'b1, 1'b0, 4'd0);
        cyc4(1'b1, 1'b0, 4'd0);
        chk("pre_rst_pwm", pwm4, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_pwm", pwm4, 0);
        chk("mid_rst_ps", ps4, 0);
        chk("mid_rst_uf", uf4, 0);
        chk("mid_rst_rdy", rdy4, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        for (int c = 0; c < 16; c++) cyc4(1'b1, 1'b0, 4'd0);
        chk_wins("post_rst", 1, '{8, 0, 0, 0, 0});
        chk("post_rst_uf", uf_cnt, 1);

        // ---------------- randomized traffic against the model ----------------
        en_r = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 39) == 0) en_r = ~en_r;
            cyc4(en_r, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
